x_pingpong_buffer: RTL and testbench

Parametrised, double-banked X-operand buffer for the matrix datapath. It loads one tile of X rows from the narrow load bus into a shadow bank, word by word, under a valid/ready handshake. It then swaps that bank in as the active bank and presents element 0 of every active row to the MAC array, shifting all rows one element per `shift`. Loading the next tile overlaps shifting of the current one. Partial (last-column) tiles are supported through a per-tile word count.

---
 rtl/x_pingpong_buffer_if.sv | 33 +++
 rtl/x_pingpong_buffer.sv | 132 +++++++++++++
 tb/tb_x_pingpong_buffer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/x_pingpong_buffer_if.sv
// Load/shift/readout signal bundle for the X-operand ping-pong buffer.
interface x_pingpong_buffer_if #(
  parameter int ROWS   = 3,
  parameter int ELEM_W = 8,
  parameter int ELEMS  = 8,
  parameter int LOAD_W = 32
);
  localparam int WPR = ELEMS * ELEM_W / LOAD_W;
  localparam int LW  = $clog2(WPR) + 1;
  localparam int SCW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  logic                     load_start;
  logic [LW-1:0]            load_len;
  logic                     load_valid;
  logic [LOAD_W-1:0]        load_data;
  logic                     load_ready;
  logic                     load_done;
  logic                     swap;
  logic                     shift;
  logic                     shift_mode;
  logic [ROWS*ELEM_W-1:0]   x_out;
  logic                     active_valid;
  logic [SCW-1:0]           shift_cnt;

  modport slave (
    input  load_start, load_len, load_valid, load_data, swap, shift, shift_mode,
    output load_ready, load_done, x_out, active_valid, shift_cnt
  );
  modport master (
    output load_start, load_len, load_valid, load_data, swap, shift, shift_mode,
    input  load_ready, load_done, x_out, active_valid, shift_cnt
  );
endinterface

// File: rtl/x_pingpong_buffer.sv
// Double-banked X-operand buffer: shadow bank fills from the load bus while
// the active bank shifts element 0 of each row out to the MAC lanes.
module x_pingpong_buffer #(
  parameter int ROWS   = 3,
  parameter int ELEM_W = 8,
  parameter int ELEMS  = 8,
  parameter int LOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  x_pingpong_buffer_if.slave   bus
);
  localparam int WPR = ELEMS * ELEM_W / LOAD_W;
  localparam int EPW = LOAD_W / ELEM_W;
  localparam int LW  = $clog2(WPR) + 1;
  localparam int SCW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  typedef logic [ROWS-1:0][ELEMS-1:0][ELEM_W-1:0] bank_t;

  bank_t [1:0]    bank_q, bank_d;
  bank_t          act_q, shd_q, act_d, shd_d;
  logic [1:0]     state_q, state_d;
  logic [LW-1:0]  len_q, len_d, len_clamp;
  logic [LW-1:0]  w_q, w_d;
  logic [RW-1:0]  r_q, r_d;
  logic           sel_q, sel_d;
  logic           av_q, av_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           swap_ok;

  assign act_q     = sel_q ? bank_q[1] : bank_q[0];
  assign shd_q     = sel_q ? bank_q[0] : bank_q[1];
  assign len_clamp = (bus.load_len == '0 || bus.load_len > LW'(WPR)) ? LW'(WPR) : bus.load_len;
  assign swap_ok   = (state_q == S_FULL) && bus.swap;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    w_d     = w_q;
    r_d     = r_q;
    sel_d   = sel_q;
    av_d    = av_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;

    // A swap in the same cycle takes precedence and the shift is dropped.
    if (bus.shift && av_q && !swap_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int e = 0; e < ELEMS-1; e++) act_d[r][e] = act_q[r][e+1];
        act_d[r][ELEMS-1] = bus.shift_mode ? '0 : act_q[r][0];
      end
      cnt_d = (cnt_q == SCW'(ELEMS-1)) ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (bus.load_start) begin
          state_d = S_LOAD;
          len_d   = len_clamp;
          w_d     = '0;
          r_d     = '0;
          shd_d   = '0;
        end else if (state_q == S_LOAD && bus.load_valid) begin
          for (int r = 0; r < ROWS; r++)
            for (int e = 0; e < ELEMS; e++)
              if (RW'(r) == r_q && LW'(e / EPW) == w_q)
                shd_d[r][e] = bus.load_data[(e % EPW)*ELEM_W +: ELEM_W];
          if (w_q == len_q - 1'b1) begin
            w_d = '0;
            if (r_q == RW'(ROWS-1)) begin
              r_d     = '0;
              state_d = S_FULL;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (bus.swap) begin
          sel_d   = ~sel_q;
          av_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bank_d[0] = sel_q ? shd_d : act_d;
    bank_d[1] = sel_q ? act_d : shd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q  <= '0;
      state_q <= S_IDLE;
      len_q   <= '0;
      w_q     <= '0;
      r_q     <= '0;
      sel_q   <= 1'b0;
      av_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bank_q  <= bank_d;
      state_q <= state_d;
      len_q   <= len_d;
      w_q     <= w_d;
      r_q     <= r_d;
      sel_q   <= sel_d;
      av_q    <= av_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready   = (state_q == S_LOAD);
  assign bus.load_done    = (state_q == S_FULL);
  assign bus.active_valid = av_q;
  assign bus.shift_cnt    = cnt_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_xout
    assign bus.x_out[r*ELEM_W +: ELEM_W] = act_q[r][0];
  end
endmodule

// File: tb/tb_x_pingpong_buffer.sv
// Bench for x_pingpong_buffer: directed tiles plus random traffic against a
// transaction-level model of the two banks.
module tb_x_pingpong_buffer;
  localparam int ROWS = 3, ELEM_W = 8, ELEMS = 8, LOAD_W = 32;
  localparam int WPR = ELEMS * ELEM_W / LOAD_W;
  localparam int EPW = LOAD_W / ELEM_W;
  localparam int LW  = $clog2(WPR) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x_pingpong_buffer_if #(.ROWS(ROWS), .ELEM_W(ELEM_W), .ELEMS(ELEMS), .LOAD_W(LOAD_W)) bus ();
  x_pingpong_buffer #(.ROWS(ROWS), .ELEM_W(ELEM_W), .ELEMS(ELEMS), .LOAD_W(LOAD_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model: banks as plain element arrays, load progress as a beat count.
  logic [ELEM_W-1:0] mb [2][ROWS][ELEMS];
  bit msel, mav, mloading, mfull;
  int mlen, mbeats, mcnt;
  logic [LOAD_W-1:0] wq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [ROWS*ELEM_W-1:0] m_x();
    logic [ROWS*ELEM_W-1:0] x;
    for (int r = 0; r < ROWS; r++) x[r*ELEM_W +: ELEM_W] = mb[msel][r][0];
    return x;
  endfunction

  task automatic model_step();
    bit swap_ok;
    int l, row, word;
    logic [ELEM_W-1:0] first;
    if (rst) begin
      for (int b = 0; b < 2; b++) for (int r = 0; r < ROWS; r++) for (int e = 0; e < ELEMS; e++) mb[b][r][e] = '0;
      msel = 0; mav = 0; mloading = 0; mfull = 0; mlen = WPR; mbeats = 0; mcnt = 0;
      return;
    end
    swap_ok = mfull && bus.swap;
    if (bus.shift && mav && !swap_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        first = mb[msel][r][0];
        for (int e = 0; e < ELEMS-1; e++) mb[msel][r][e] = mb[msel][r][e+1];
        mb[msel][r][ELEMS-1] = bus.shift_mode ? '0 : first;
      end
      mcnt = (mcnt + 1) % ELEMS;
    end
    if (!mfull && bus.load_start) begin
      l = int'(bus.load_len);
      mlen = (l == 0 || l > WPR) ? WPR : l;
      mloading = 1; mbeats = 0;
      for (int r = 0; r < ROWS; r++) for (int e = 0; e < ELEMS; e++) mb[!msel][r][e] = '0;
    end else if (mloading && bus.load_valid) begin
      row = mbeats / mlen; word = mbeats % mlen;
      for (int k = 0; k < EPW; k++) mb[!msel][row][word*EPW + k] = bus.load_data[k*ELEM_W +: ELEM_W];
      mbeats++;
      if (mbeats == ROWS * mlen) begin mloading = 0; mfull = 1; end
    end else if (mfull && bus.swap) begin
      msel = !msel; mav = 1; mcnt = 0; mfull = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_out", bus.x_out, m_x());
      chk("load_ready", bus.load_ready, mloading);
      chk("load_done", bus.load_done, mfull);
      chk("active_valid", bus.active_valid, mav);
      chk("shift_cnt", bus.shift_cnt, mcnt);
    end
  end

  task automatic do_load(input int len, input int nbeats, input int from, input bit start,
                         input bit toggle, input bit shf);
    int idx, cyc;
    bit rdy, v;
    if (start) begin
      bus.load_start = 1; bus.load_len = LW'(len);
      bus.load_valid = 1; bus.load_data = 32'hDEADBEEF; bus.shift = 0;
      tick();
      bus.load_start = 0;
    end
    idx = from; cyc = 0;
    while (idx < from + nbeats && cyc < 100) begin
      v = toggle ? cyc[0] : 1'b1;
      bus.load_valid = v; bus.load_data = wq[idx]; bus.shift = shf;
      rdy = bus.load_ready;
      tick();
      if (v && rdy) idx++;
      cyc++;
    end
    bus.load_valid = 0; bus.shift = 0;
    if (idx < from + nbeats) begin
      total++; bad++;
      $display("FAIL load_timeout got=%0d beats exp=%0d", idx - from, nbeats);
    end
  endtask

  task automatic do_swap();
    bus.swap = 1; tick(); bus.swap = 0;
  endtask

  task automatic shifts(input int n, input bit mode);
    bus.shift = 1; bus.shift_mode = mode;
    repeat (n) tick();
    bus.shift = 0;
  endtask

  task automatic set_t1();
    wq = '{32'h03020100, 32'h07060504, 32'h13121110, 32'h17161514, 32'h23222120, 32'h27262524};
  endtask
  task automatic set_t2();
    wq = '{32'h03020100, 32'h13121110, 32'h23222120};
  endtask

  initial begin
    logic [ROWS*ELEM_W-1:0] bx;
    bus.load_start = 0; bus.load_len = '0; bus.load_valid = 0; bus.load_data = '0;
    bus.swap = 0; bus.shift = 0; bus.shift_mode = 0;
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst x_out", bus.x_out, 0);
    chk("rst load_ready", bus.load_ready, 0);
    chk("rst load_done", bus.load_done, 0);
    chk("rst active_valid", bus.active_valid, 0);
    shifts(3, 0);
    chk("noactive shift_cnt", bus.shift_cnt, 0);
    chk("noactive x_out", bus.x_out, 0);

    // Full-width tile, rotate
    set_t1(); do_load(2, 6, 0, 1, 0, 0);
    chk("t1 load_done", bus.load_done, 1);
    do_swap();
    chk("t1 swap x_out", bus.x_out, 24'h201000);
    shifts(3, 0);
    chk("t1 rot3", bus.x_out, 24'h231303);
    shifts(5, 0);
    chk("t1 rot8", bus.x_out, 24'h201000);
    chk("t1 cnt8", bus.shift_cnt, 0);

    // Partial tile, zero-fill
    set_t2(); do_load(1, 3, 0, 1, 0, 0);
    chk("t2 load_done", bus.load_done, 1);
    do_swap();
    chk("t2 swap x_out", bus.x_out, 24'h201000);
    shifts(3, 1);
    chk("t2 zf3", bus.x_out, 24'h231303);
    shifts(1, 1);
    chk("t2 zf4", bus.x_out, 24'h000000);

    // Ping-pong: rotate A while B loads with bubbles
    set_t1(); do_load(2, 6, 0, 1, 0, 0); do_swap();
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back($urandom);
    for (int r = 0; r < ROWS; r++) bx[r*ELEM_W +: ELEM_W] = wq[r*2][ELEM_W-1:0];
    bus.shift_mode = 0;
    do_load(2, 6, 0, 1, 1, 1);
    chk("pp during load x_out", bus.x_out, 24'h241404);
    chk("pp during load cnt", bus.shift_cnt, 4);
    do_swap();
    chk("pp swap x_out", bus.x_out, bx);
    chk("pp swap cnt", bus.shift_cnt, 0);

    // Swap in LOAD ignored; swap+shift in FULL
    set_t2(); do_load(1, 1, 0, 1, 0, 0);
    do_swap();
    chk("swap in load x_out", bus.x_out, bx);
    chk("swap in load ready", bus.load_ready, 1);
    do_load(1, 2, 1, 0, 0, 0);
    shifts(2, 0);
    bus.swap = 1; bus.shift = 1; tick(); bus.swap = 0; bus.shift = 0;
    chk("swap+shift x_out", bus.x_out, 24'h201000);
    chk("swap+shift cnt", bus.shift_cnt, 0);

    // Reset in the middle of a load
    set_t1(); do_load(2, 2, 0, 1, 0, 0);
    rst = 1; bus.shift = 1; tick(); rst = 0; bus.shift = 0;
    chk("midrst ready", bus.load_ready, 0);
    chk("midrst done", bus.load_done, 0);
    chk("midrst av", bus.active_valid, 0);
    chk("midrst x_out", bus.x_out, 0);
    do_load(2, 6, 0, 1, 0, 0); do_swap();
    chk("postrst x_out", bus.x_out, 24'h201000);

    // Restart mid-load: old words must not survive
    wq = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hB3B2B1B0};
    do_load(2, 3, 0, 1, 0, 0);
    set_t2(); do_load(1, 3, 0, 1, 0, 0);
    do_swap();
    chk("restart x_out", bus.x_out, 24'h201000);
    shifts(4, 0);
    chk("restart rot4", bus.x_out, 24'h000000);
    shifts(4, 0);
    chk("restart rot8", bus.x_out, 24'h201000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.load_start = ($urandom_range(0, 11) == 0);
      bus.load_len   = LW'($urandom_range(0, 3));
      bus.load_valid = $urandom_range(0, 1);
      bus.load_data  = $urandom;
      bus.swap       = ($urandom_range(0, 5) == 0);
      bus.shift      = $urandom_range(0, 1);
      bus.shift_mode = $urandom_range(0, 1);
      tick();
    end
    rst = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
